instr_fetch_ctrl: RTL and testbench

//  Sequences the byte-wide instruction memory: walks PC, reads 4 bytes per

---
 rtl/instr_fetch_ctrl_if.sv | 64 ++++++
 rtl/instr_fetch_ctrl.sv | 167 ++++++++++++++++
 tb/tb_instr_fetch_ctrl.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_ctrl_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_ctrl_if
//   Bundles the instruction-memory read port, the pipeline control inputs
//   (stall / redirect) and the fetch-to-decode handshake of instr_fetch_ctrl.
//
//   master : the fetch controller (drives memory strobe/address, instruction
//            word and its valid, current PC)
//   slave  : the surroundings (memory, PC/branch logic, decode stage)
//
//   mem_en       fetch -> mem     byte read strobe
//   mem_addr     fetch -> mem     byte address
//   mem_rdata    mem   -> fetch   byte at mem_addr, same cycle
//   stall        pipe  -> fetch   freeze fetch progress
//   redirect     pipe  -> fetch   load redirect_pc, abort current fetch
//   redirect_pc  pipe  -> fetch   redirect target (low two bits ignored)
//   instr        fetch -> decode  assembled big-endian instruction word
//   instr_pc     fetch -> decode  PC of instr
//   instr_valid  fetch -> decode  instr/instr_pc valid
//   instr_ready  decode -> fetch  decode accepts instr
//   pc           fetch -> pipe    PC of the instruction being fetched
// -----------------------------------------------------------------------------
interface instr_fetch_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rdata;
    logic              stall;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic [31:0]       instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              instr_ready;
    logic [ADDR_W-1:0] pc;

    modport master (
        output mem_en,
        output mem_addr,
        input  mem_rdata,
        input  stall,
        input  redirect,
        input  redirect_pc,
        output instr,
        output instr_pc,
        output instr_valid,
        input  instr_ready,
        output pc
    );

    modport slave (
        input  mem_en,
        input  mem_addr,
        output mem_rdata,
        output stall,
        output redirect,
        output redirect_pc,
        input  instr,
        input  instr_pc,
        input  instr_valid,
        output instr_ready,
        input  pc
    );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// instr_fetch_ctrl
//   Fetch sequencer for a byte-wide instruction memory. Reads the four bytes of
//   the instruction at pc on consecutive cycles (pc, pc+1, pc+2, pc+3),
//   assembles them big-endian (byte at pc lands in [31:24]) and offers the word
//   to decode over a valid/ready handshake. The pipeline can freeze fetch with
//   stall or restart it at a new PC with redirect.
//
//   Ports
//     clk   rising-edge clock
//     rst   synchronous reset, active low
//     bus   instr_fetch_ctrl_if.master: memory read port, stall/redirect,
//           instruction handshake to decode and current pc
//
//   Parameters
//     ADDR_W    byte address / PC width (memory depth 2**ADDR_W bytes)
//     RESET_PC  PC loaded at reset (word aligned)
//
//   States
//     FETCH  one byte per un-stalled cycle, cnt selects the byte (0..3)
//     HOLD   full word presented with instr_valid, waiting for instr_ready
// -----------------------------------------------------------------------------
module instr_fetch_ctrl #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    instr_fetch_ctrl_if.master bus
);

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_t;

    // Clears the byte-offset bits so every PC this block holds is word aligned.
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:2], 2'b00};
    endfunction

    // Places one fetched byte into its lane of the partial word: byte k of the
    // instruction belongs in lane 3-k, lanes 3..1 are held here until the last
    // byte arrives.
    function automatic logic [23:0] insert_byte(input logic [23:0] part,
                                                input logic [1:0]  k,
                                                input logic [7:0]  b);
        logic [23:0] r;
        r = part;
        case (k)
            2'd0:    r[23:16] = b;
            2'd1:    r[15:8]  = b;
            2'd2:    r[7:0]   = b;
            default: r        = part;
        endcase
        return r;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t            state_q,    state_n;
    logic [1:0]        cnt_q,      cnt_n;
    logic [ADDR_W-1:0] pc_q,       pc_n;
    logic [23:0]       part_q,     part_n;
    logic [31:0]       instr_q,    instr_n;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_n;
    logic              valid_q,    valid_n;

    logic              fetching;
    logic              handshake;

    assign fetching  = (state_q == FETCH) && !bus.stall;
    assign handshake = valid_q && bus.instr_ready;

    // -------------------------------------------------------------------------
    // Next-state / datapath control
    // -------------------------------------------------------------------------
    always_comb begin
        state_n    = state_q;
        cnt_n      = cnt_q;
        pc_n       = pc_q;
        part_n     = part_q;
        instr_n    = instr_q;
        instr_pc_n = instr_pc_q;
        valid_n    = valid_q;

        if (bus.redirect) begin
            // Redirect wins over stall and over the HOLD fall-through. A
            // handshake in this cycle still completes on the decode side; only
            // the pc+4 continuation is replaced by the target. Nothing is
            // captured, so the aborted word never reaches instr.
            state_n = FETCH;
            cnt_n   = 2'd0;
            pc_n    = word_align(bus.redirect_pc);
            valid_n = 1'b0;
        end else begin
            case (state_q)
                FETCH: begin
                    if (!bus.stall) begin
                        cnt_n = cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            instr_n    = {part_q, bus.mem_rdata};
                            instr_pc_n = pc_q;
                            valid_n    = 1'b1;
                            state_n    = HOLD;
                        end else begin
                            part_n = insert_byte(part_q, cnt_q, bus.mem_rdata);
                        end
                    end
                end
                HOLD: begin
                    // Stall has no effect here: the word is complete and the
                    // handshake must not be blocked by a frozen fetch.
                    if (handshake) begin
                        valid_n = 1'b0;
                        pc_n    = pc_q + ADDR_W'(4);
                        cnt_n   = 2'd0;
                        state_n = FETCH;
                    end
                end
                default: begin
                    state_n = FETCH;
                    cnt_n   = 2'd0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Registers: control and the presented word
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= FETCH;
            cnt_q      <= 2'd0;
            pc_q       <= word_align(RESET_PC);
            instr_q    <= 32'd0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_n;
            cnt_q      <= cnt_n;
            pc_q       <= pc_n;
            instr_q    <= instr_n;
            instr_pc_q <= instr_pc_n;
            valid_q    <= valid_n;
        end
    end

    // Partial-word bytes need no reset: they only become visible once all
    // three are overwritten by a complete fetch.
    always_ff @(posedge clk) begin
        part_q <= part_n;
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.mem_en      = rst && fetching;
    assign bus.mem_addr    = pc_q + ADDR_W'(cnt_q);
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.instr_valid = valid_q;
    assign bus.pc          = pc_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_ctrl
//   Bench for instr_fetch_ctrl with a 256-byte instruction memory model.
//   Expected words are queued when the fetch that produces them is launched and
//   checked by a monitor at every decode handshake.
// -----------------------------------------------------------------------------
module tb_instr_fetch_ctrl;

    localparam int ADDR_W = 8;

    logic clk;
    logic rst;

    instr_fetch_ctrl_if #(.ADDR_W(ADDR_W)) bus_if ();

    instr_fetch_ctrl #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (8'h00)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    logic [7:0] mem [0:255];
    assign bus_if.mem_rdata = mem[bus_if.mem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  pc;
        logic [31:0] w;
    } exp_t;

    typedef struct {
        logic [7:0]  tgt;
        int          stall_at;
        int          stall_len;
        int          ready_wait;
        logic        hold_stall;
        logic [7:0]  exp_pc;
        logic [31:0] exp_instr;
        int          exp_lat;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[5];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   hs_count = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [7:0] pc, input logic [31:0] w);
        exp_t e;
        e.pc = pc;
        e.w  = w;
        sb.push_back(e);
    endtask

    // Handshake monitor: inputs change 1 time unit after posedge, so the
    // negedge value is what the next posedge samples.
    always @(negedge clk) begin
        if (rst && bus_if.instr_valid && bus_if.instr_ready) begin
            hs_count++;
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected: got handshake pc %h instr %h expected none",
                         bus_if.instr_pc, bus_if.instr);
            end else begin
                mon_e = sb.pop_front();
                chk("sb_instr", bus_if.instr, mon_e.w);
                chk("sb_instr_pc", {24'd0, bus_if.instr_pc}, {24'd0, mon_e.pc});
            end
        end
    end

    task automatic wait_valid(input string name, input int budget, output int n);
        n = 0;
        while (!bus_if.instr_valid && n < budget) begin
            step();
            n++;
        end
        if (!bus_if.instr_valid) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: got no instr_valid within %0d cycles expected valid", name, n);
        end
    endtask

    task automatic run_vec(input vec_t v);
        logic [7:0] a;
        int         lat;
        int         k;
        int         hs0;
        logic       stalled;
        push_exp(v.exp_pc, v.exp_instr);
        bus_if.instr_ready = 1'b0;
        bus_if.redirect    = 1'b1;
        bus_if.redirect_pc = v.tgt;
        step();
        bus_if.redirect = 1'b0;
        #1;
        lat     = 0;
        k       = 0;
        stalled = 1'b0;
        while (!bus_if.instr_valid && lat < 40) begin
            if (v.stall_len != 0 && !stalled && k == v.stall_at) begin
                stalled      = 1'b1;
                bus_if.stall = 1'b1;
                #1;
                for (int s = 0; s < v.stall_len; s++) begin
                    a = v.exp_pc + k[7:0];
                    chk("stall_mem_en", {31'd0, bus_if.mem_en}, 32'd0);
                    chk("stall_addr", {24'd0, bus_if.mem_addr}, {24'd0, a});
                    step();
                    lat++;
                end
                bus_if.stall = 1'b0;
                #1;
            end else begin
                a = v.exp_pc + k[7:0];
                chk("fetch_addr", {24'd0, bus_if.mem_addr}, {24'd0, a});
                chk("fetch_mem_en", {31'd0, bus_if.mem_en}, 32'd1);
                step();
                lat++;
                k++;
            end
        end
        chk("latency", lat, v.exp_lat);
        bus_if.stall = v.hold_stall;
        #1;
        for (int w = 0; w <= v.ready_wait; w++) begin
            chk("hold_valid", {31'd0, bus_if.instr_valid}, 32'd1);
            chk("hold_instr", bus_if.instr, v.exp_instr);
            chk("hold_instr_pc", {24'd0, bus_if.instr_pc}, {24'd0, v.exp_pc});
            chk("hold_mem_en", {31'd0, bus_if.mem_en}, 32'd0);
            if (w < v.ready_wait) step();
        end
        hs0 = hs_count;
        bus_if.instr_ready = 1'b1;
        step();
        bus_if.instr_ready = 1'b0;
        bus_if.stall       = 1'b0;
        #1;
        a = v.exp_pc + 8'd4;
        chk("post_hs_valid", {31'd0, bus_if.instr_valid}, 32'd0);
        chk("post_hs_pc", {24'd0, bus_if.pc}, {24'd0, a});
        chk("post_hs_addr", {24'd0, bus_if.mem_addr}, {24'd0, a});
        chk("post_hs_mem_en", {31'd0, bus_if.mem_en}, 32'd1);
        chk("post_hs_count", hs_count, hs0 + 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no end of test expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int hs0;

        for (int i = 0; i < 256; i++) mem[i] = ~i[7:0];
        mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'h56; mem[3] = 8'h78;
        mem[4] = 8'h9A; mem[5] = 8'hBC; mem[6] = 8'hDE; mem[7] = 8'hF0;

        //          tgt    at len wait hstl  exp_pc  exp_instr      lat
        vecs[0] = '{8'h43, 0, 0,  2,   1'b0, 8'h40,  32'hBFBEBDBC,  4};
        vecs[1] = '{8'h10, 2, 3,  6,   1'b0, 8'h10,  32'hEFEEEDEC,  7};
        vecs[2] = '{8'hFD, 0, 1,  0,   1'b1, 8'hFC,  32'h03020100,  5};
        vecs[3] = '{8'h82, 3, 2,  1,   1'b0, 8'h80,  32'h7F7E7D7C,  6};
        vecs[4] = '{8'h06, 0, 0,  3,   1'b1, 8'h04,  32'h9ABCDEF0,  4};

        rst                = 1'b0;
        bus_if.stall       = 1'b0;
        bus_if.redirect    = 1'b0;
        bus_if.redirect_pc = 8'h00;
        bus_if.instr_ready = 1'b0;
        repeat (3) step();

        // Reset state
        chk("rst_valid", {31'd0, bus_if.instr_valid}, 32'd0);
        chk("rst_instr", bus_if.instr, 32'd0);
        chk("rst_instr_pc", {24'd0, bus_if.instr_pc}, 32'd0);
        chk("rst_pc", {24'd0, bus_if.pc}, 32'd0);
        chk("rst_mem_en", {31'd0, bus_if.mem_en}, 32'd0);
        chk("rst_mem_addr", {24'd0, bus_if.mem_addr}, 32'd0);

        // Reset release with ready high: words at 0 and 4
        bus_if.instr_ready = 1'b1;
        push_exp(8'h00, 32'h12345678);
        rst = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            step();
            chk("boot_valid", {31'd0, bus_if.instr_valid}, {31'd0, (i == 4 || i == 9)});
            if (i == 4) chk("boot_pc0", {24'd0, bus_if.instr_pc}, 32'h00);
            if (i == 9) begin
                chk("boot_instr1", bus_if.instr, 32'h9ABCDEF0);
                chk("boot_pc1", {24'd0, bus_if.instr_pc}, 32'h04);
                bus_if.instr_ready = 1'b0;
            end
        end

        // Table: redirect, optional stall, ready back-pressure, handshake
        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Redirect in the middle of a fetch (cnt == 1)
        step();
        chk("mid_addr_cnt1", {24'd0, bus_if.mem_addr}, 32'h09);
        bus_if.redirect    = 1'b1;
        bus_if.redirect_pc = 8'h43;
        push_exp(8'h40, 32'hBFBEBDBC);
        step();
        bus_if.redirect = 1'b0;
        #1;
        chk("mid_redirect_addr", {24'd0, bus_if.mem_addr}, 32'h40);
        chk("mid_redirect_valid", {31'd0, bus_if.instr_valid}, 32'd0);
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("mid_valid", {31'd0, bus_if.instr_valid}, {31'd0, (i == 4)});
        end
        chk("mid_instr_pc", {24'd0, bus_if.instr_pc}, 32'h40);

        // Redirect in the same cycle as a handshake
        hs0 = hs_count;
        bus_if.instr_ready = 1'b1;
        bus_if.redirect    = 1'b1;
        bus_if.redirect_pc = 8'h21;
        push_exp(8'h20, 32'hDFDEDDDC);
        step();
        bus_if.redirect = 1'b0;
        #1;
        chk("rdhs_valid", {31'd0, bus_if.instr_valid}, 32'd0);
        chk("rdhs_pc", {24'd0, bus_if.pc}, 32'h20);
        chk("rdhs_addr", {24'd0, bus_if.mem_addr}, 32'h20);
        wait_valid("rdhs_wait", 10, n);
        chk("rdhs_lat", n, 4);
        chk("rdhs_instr_pc", {24'd0, bus_if.instr_pc}, 32'h20);
        step();
        bus_if.instr_ready = 1'b0;
        chk("rdhs_count", hs_count, hs0 + 2);
        chk("rdhs_next_pc", {24'd0, bus_if.pc}, 32'h24);

        // Reset while holding a word
        wait_valid("hold_rst_wait", 10, n);
        chk("hold_rst_pre_pc", {24'd0, bus_if.instr_pc}, 32'h24);
        rst = 1'b0;
        step();
        chk("hold_rst_valid", {31'd0, bus_if.instr_valid}, 32'd0);
        chk("hold_rst_pc", {24'd0, bus_if.pc}, 32'h00);
        chk("hold_rst_instr", bus_if.instr, 32'd0);
        chk("hold_rst_instr_pc", {24'd0, bus_if.instr_pc}, 32'd0);
        chk("hold_rst_mem_en", {31'd0, bus_if.mem_en}, 32'd0);
        chk("hold_rst_addr", {24'd0, bus_if.mem_addr}, 32'h00);
        rst = 1'b1;
        bus_if.instr_ready = 1'b1;
        push_exp(8'h00, 32'h12345678);
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("reboot_valid", {31'd0, bus_if.instr_valid}, {31'd0, (i == 4)});
        end
        step();
        bus_if.instr_ready = 1'b0;
        step();

        chk("sb_drained", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
